mul_seq_16: RTL and testbench
=============================

# mul_seq_16

Sequential 16×16 → 32-bit unsigned shift-and-add multiplier controller for the ALU. It time-shares one `cla_16` adder instance over 16 iterations and returns a 32-bit product with a start/done handshake. It sits beside the ALU's combinational ops and serves the MUL instruction, with its product written to the HI/LO pair by the datapath.

## Interface

Parameters:
- None. Width is fixed at 16×16 to match `cla_16`.

Ports:
- `in_clk`  in  1  system clock; all state updates on its rising edge.
- `in_reset`  in  1  synchronous, active-high reset.
- `in_start`  in  1  request a multiply. Sampled only in IDLE or DONE.
- `in_multiplicand`  in  16  operand A. Sampled on the accepting edge only.
- `in_multiplier`  in  16  operand B. Sampled on the accepting edge only.
- `out_busy`  out  1  high while in RUN.
- `out_done`  out  1  one-cycle pulse; high while in DONE.
- `out_product`  out  32  last completed product; held until the next completion.

## Operation

Internal registers:
- `mcand[15:0]`: latched multiplicand.
- `acc_hi[15:0]`: partial-product high half.
- `acc_lo[15:0]`: multiplier and low product bits.
- `count[3:0]`: iteration counter.
- `state`: one of IDLE, RUN, DONE.
- `out_product[31:0]`: result register.

Adder use:
- One `cla_16` instance.
- `in_x` = `acc_hi`.
- `in_y` = `mcand` when `acc_lo[0]` = 1, otherwise 16'h0000.
- `in_carry` = 0.
- Only `out_sum` and `out_carry` are used. `out_generate` and `out_propogate` are left unconnected.

State machine:
- IDLE:
  - `in_start` = 1: load `mcand` ← A, `acc_hi` ← 0, `acc_lo` ← B, `count` ← 0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Update {`acc_hi`, `acc_lo`} ← {`out_carry`, `out_sum`, `acc_lo[15:1]`}. This is a 33-bit value shifted right by one.
  - `count` ← `count` + 1.
  - When `count` = 15 on this edge, also load `out_product` ← the new {`acc_hi`, `acc_lo`} and go to DONE.
  - `in_start` is ignored in RUN. No queuing and no error flag.
- DONE:
  - Lasts exactly one cycle with `out_done` = 1.
  - `in_start` = 1: perform the IDLE load and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.

Arithmetic and width rules:
- Operands and product are unsigned.
- The carry out of each add is captured into bit 15 of `acc_hi` by the shift, so no overflow is possible.
- The product is exact over the full 32 bits.

Reset:
- Applies in any state, including mid-RUN.
- State ← IDLE; `mcand`, `acc_hi`, `acc_lo`, `count` ← 0.
- `out_product` ← 32'h0, `out_busy` ← 0, `out_done` ← 0.
- An aborted operation produces no `out_done` and leaves `out_product` at 0.
- `in_reset` has priority over `in_start` on the same edge.

## Timing

Edge numbering: E0 is the edge that accepts `in_start`.
- E0: load. `out_busy` = 1 after E0.
- E1..E16: the 16 iterations.
- E16: `out_product` is valid after this edge. State enters DONE; `out_busy` = 0 and `out_done` = 1 after E16.
- E17: `out_done` returns to 0, unless it is re-armed by a new operation completing.
- Latency from the accepting edge to `out_done` high is 16 cycles. Throughput is 17 cycles per operation when back-to-back.
- `out_busy` and `out_done` are never high together. Both are registered state decodes with no combinational input-to-output path.
- The adder path (`acc_hi`/`mcand` → `cla_16` → `acc` registers) is a single-cycle path.
- Operand inputs may change freely after E0 without affecting the result.

## Test plan

1. Reset, then A=16'h0003, B=16'h0005, `in_start` for one cycle.
   - `out_busy` = 1 for exactly 16 cycles.
   - `out_done` pulses once, 16 cycles after the accepting edge, with `out_product` = 32'h0000000F.
   - `out_product` is held afterwards.
2. Maximum operands: A=16'hFFFF, B=16'hFFFF.
   - `out_product` = 32'hFFFE0001, which exercises the carry capture on every iteration.
3. Zero operand: A=16'h0000, B=16'h1234.
   - `out_product` = 32'h00000000.
   - Then A=16'h1234, B=16'h0001 gives 32'h00001234.
4. Start while busy: during RUN of A=16'h00FF, B=16'h0101, pulse `in_start` with A=16'hFFFF, B=16'hFFFF.
   - The second request is ignored.
   - The result is 32'h0000FFFF with a single `out_done`.
5. Back-to-back: hold `in_start` high with new operands (A=16'h8000, B=16'h0002) during the DONE cycle.
   - The next run starts immediately.
   - The second `out_done` comes 17 cycles after the first, with `out_product` = 32'h00010000.
6. Reset mid-operation: assert `in_reset` at iteration 8 of A=16'h1234, B=16'h5678.
   - All outputs read 0 after the edge, and no `out_done` follows.
   - A subsequent start of A=16'h1234, B=16'h5678 yields 32'h06260060.

Source files
------------

// File: rtl/mul_seq_16_if.sv
// mul_seq_16_if: start/done handshake and operand/product bus for mul_seq_16.
// master drives start and operands; slave returns busy, done and product.
interface mul_seq_16_if;
  logic        in_start;
  logic [15:0] in_multiplicand;
  logic [15:0] in_multiplier;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_product;

  modport master (
    output in_start, in_multiplicand, in_multiplier,
    input  out_busy, out_done, out_product
  );

  modport slave (
    input  in_start, in_multiplicand, in_multiplier,
    output out_busy, out_done, out_product
  );
endinterface

// File: rtl/mul_seq_16.sv
// mul_seq_16: 16x16->32 unsigned shift-and-add multiplier on one cla_16.
// Ports: in_clk, in_reset (sync, active high), bus (mul_seq_16_if.slave).
module cla_16 (
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic        in_carry,
  output logic [15:0] out_sum,
  output logic        out_carry,
  output logic        out_generate,
  output logic        out_propogate
);
  logic [15:0] g, p;
  logic [16:0] c;
  logic [3:0]  gg, pp;
  logic [4:0]  cg;

  always_comb begin
    g = in_x & in_y;
    p = in_x ^ in_y;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | ((&p[4*k+3 -: 3]) & g[4*k]);
      pp[k] = &p[4*k+3 -: 4];
    end
    cg[0] = in_carry;
    for (int k = 0; k < 4; k++)
      cg[k+1] = gg[k] | (pp[k] & cg[k]);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = cg[k];
      for (int j = 0; j < 3; j++)
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
    end
    c[16] = cg[4];
  end

  assign out_sum       = p ^ c[15:0];
  assign out_carry     = c[16];
  assign out_generate  = gg[3]
                       | (pp[3] & gg[2])
                       | (pp[3] & pp[2] & gg[1])
                       | (pp[3] & pp[2] & pp[1] & gg[0]);
  assign out_propogate = &pp;
endmodule

module mul_seq_16 (
  input logic         in_clk,
  input logic         in_reset,
  mul_seq_16_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_n;
  logic        load, last;
  logic [15:0] mcand, acc_hi, acc_lo;
  logic [3:0]  count;
  logic [15:0] sum;
  logic        carry;
  logic [31:0] shifted;

  cla_16 u_add (
    .in_x         (acc_hi),
    .in_y         (acc_lo[0] ? mcand : 16'h0000),
    .in_carry     (1'b0),
    .out_sum      (sum),
    .out_carry    (carry),
    .out_generate (),
    .out_propogate()
  );

  // 33-bit {carry,sum,acc_lo} shifted right by one; carry lands in bit 31
  assign shifted = {carry, sum, acc_lo[15:1]};

  always_comb begin
    state_n = state;
    load    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (count == 4'hF) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (bus.in_start) begin
          load    = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      mcand           <= '0;
      acc_hi          <= '0;
      acc_lo          <= '0;
      count           <= '0;
      bus.out_product <= '0;
    end else if (load) begin
      mcand  <= bus.in_multiplicand;
      acc_hi <= '0;
      acc_lo <= bus.in_multiplier;
      count  <= '0;
    end else if (state == RUN) begin
      {acc_hi, acc_lo} <= shifted;
      count            <= count + 4'd1;
      if (last) bus.out_product <= shifted;
    end
  end

  assign bus.out_busy = (state == RUN);
  assign bus.out_done = (state == DONE);
endmodule

// File: tb/tb_mul_seq_16.sv
// tb_mul_seq_16: directed and random checks of mul_seq_16 against a*b.
// Drives on negedge, samples 1ns after posedge.
module tb_mul_seq_16;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [31:0] last_prod;

  mul_seq_16_if bus ();

  mul_seq_16 dut (
    .in_clk  (clk),
    .in_reset(rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] a,
                                        input logic [15:0] b);
    return {16'h0, a} * {16'h0, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.in_start        = 1'b1;
    bus.in_multiplicand = a;
    bus.in_multiplier   = b;
    tick();
    bus.in_start        = 1'b0;
    bus.in_multiplicand = 16'($urandom);
    bus.in_multiplier   = 16'($urandom);
  endtask

  // n: edges until done, bc: busy samples seen, held: product stable
  task automatic wait_done(output int n, output int bc, output int held);
    n    = 0;
    bc   = bus.out_busy ? 1 : 0;
    held = 1;
    while (!bus.out_done && n < 40) begin
      if (bus.out_product !== last_prod) held = 0;
      tick();
      n++;
      if (bus.out_busy) bc++;
      if (bus.out_busy && bus.out_done) held = 0;
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b);
    int n, bc, held;
    logic [31:0] exp;
    exp = model(a, b);
    accept(a, b);
    chk("busy_e0", {31'h0, bus.out_busy}, 32'h1);
    wait_done(n, bc, held);
    chk("latency", n, 16);
    chk("busy_cycles", bc, 16);
    chk("held_mid", held, 1);
    chk("product", bus.out_product, exp);
    chk("done_e16", {31'h0, bus.out_done}, 32'h1);
    chk("busy_e16", {31'h0, bus.out_busy}, 32'h0);
    tick();
    chk("done_pulse", {31'h0, bus.out_done}, 32'h0);
    chk("prod_hold", bus.out_product, exp);
    last_prod = exp;
  endtask

  initial begin
    int n, bc, held, seen;
    logic [31:0] exp;
    compared            = 0;
    mismatched          = 0;
    last_prod           = 32'h0;
    rst                 = 1'b1;
    bus.in_start        = 1'b0;
    bus.in_multiplicand = 16'h0;
    bus.in_multiplier   = 16'h0;
    tick();
    tick();
    chk("rst_busy", {31'h0, bus.out_busy}, 32'h0);
    chk("rst_done", {31'h0, bus.out_done}, 32'h0);
    chk("rst_prod", bus.out_product, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'h0003, 16'h0005);
    chk("t1_const", last_prod, 32'h0000000F);
    repeat (3) tick();
    chk("t1_hold", bus.out_product, 32'h0000000F);

    do_op(16'hFFFF, 16'hFFFF);
    chk("t2_const", last_prod, 32'hFFFE0001);
    do_op(16'h0000, 16'h1234);
    chk("t3a_const", last_prod, 32'h0);
    do_op(16'h1234, 16'h0001);
    chk("t3b_const", last_prod, 32'h00001234);

    accept(16'h00FF, 16'h0101);
    repeat (4) tick();
    @(negedge clk);
    bus.in_start        = 1'b1;
    bus.in_multiplicand = 16'hFFFF;
    bus.in_multiplier   = 16'hFFFF;
    tick();
    bus.in_start = 1'b0;
    wait_done(n, bc, held);
    chk("t4_latency", n, 11);
    chk("t4_product", bus.out_product, 32'h0000FFFF);
    tick();
    chk("t4_single_done", {31'h0, bus.out_done}, 32'h0);
    chk("t4_idle", {31'h0, bus.out_busy}, 32'h0);
    last_prod = 32'h0000FFFF;

    exp = model(16'h7A5C, 16'hC3E1);
    accept(16'h7A5C, 16'hC3E1);
    wait_done(n, bc, held);
    chk("t5_first", bus.out_product, exp);
    last_prod           = exp;
    bus.in_start        = 1'b1;
    bus.in_multiplicand = 16'h8000;
    bus.in_multiplier   = 16'h0002;
    tick();
    bus.in_start = 1'b0;
    chk("t5_rearm_busy", {31'h0, bus.out_busy}, 32'h1);
    chk("t5_rearm_done", {31'h0, bus.out_done}, 32'h0);
    wait_done(n, bc, held);
    chk("t5_gap", n + 1, 17);
    chk("t5_product", bus.out_product, 32'h00010000);
    last_prod = 32'h00010000;
    tick();

    accept(16'h1234, 16'h5678);
    repeat (8) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t6_busy", {31'h0, bus.out_busy}, 32'h0);
    chk("t6_done", {31'h0, bus.out_done}, 32'h0);
    chk("t6_prod", bus.out_product, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      tick();
      if (bus.out_done || bus.out_busy) seen = 1;
    end
    chk("t6_no_done", seen, 0);
    last_prod = 32'h0;
    do_op(16'h1234, 16'h5678);
    chk("t6_const", last_prod, 32'h06260060);

    @(negedge clk);
    rst          = 1'b1;
    bus.in_start = 1'b1;
    tick();
    chk("rst_prio", {31'h0, bus.out_busy}, 32'h0);
    chk("rst_prio_prod", bus.out_product, 32'h0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_start = 1'b0;
    last_prod    = 32'h0;

    for (int i = 0; i < 10; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0) a = 16'h8000;
      if (i == 1) b = 16'hFFFF;
      do_op(a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
